harvard_seq_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the Harvard datapath.
- Owns the 6-bit program counter.
- Latches the instruction word read from instruction memory.
- Starts the ALU and waits for its completion handshake.
- Issues the register-file write strobe.
- Resolves jumps and zero-branches, and halts on the HALT opcode.
It replaces the free-running PC counter as the single source of instruction-memory addresses.

---
 rtl/harvard_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_harvard_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harvard_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : harvard_seq_ctrl
// Purpose  : Multi-cycle sequencer for the Harvard datapath (PC, IR, ALU
//            handshake, register-file write strobe, jumps/branches, halt).
// Revision : 1.0  initial release
// ============================================================================
module harvard_seq_ctrl #(
  parameter int PC_W        = 6,
  parameter int ALU_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      instr_in,
  input  logic             alu_done,
  input  logic             alu_zero,
  output logic [PC_W-1:0]  pc,
  output logic [31:0]      ir,
  output logic             alu_start,
  output logic [5:0]       alu_op,
  output logic             rf_we,
  output logic             fetch_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

  localparam logic [5:0] OP_JMP  = 6'h10;
  localparam logic [5:0] OP_BEQZ = 6'h11;
  localparam logic [5:0] OP_HALT = 6'h3F;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [5:0]       w_op;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0] w_ret_inc;
  logic             w_is_alu;

  assign w_op      = ir_q[31:26];
  assign w_target  = ir_q[PC_W-1:0];
  assign w_pc_inc  = pc_q + PC_W'(1);
  assign w_ret_inc = (&ret_q) ? ret_q : ret_q + CNT_W'(1);
  assign w_is_alu  = (w_op[5:4] == 2'b00) && (w_op != 6'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    ret_d   = ret_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = instr_in;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_alu || (w_op == OP_BEQZ)) begin
          tmo_d   = '0;
          state_d = S_EXEC;
        end else if (w_op == OP_JMP) begin
          pc_d    = w_target;
          ret_d   = w_ret_inc;
          state_d = S_FETCH;
        end else if (w_op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          pc_d    = w_pc_inc;
          ret_d   = w_ret_inc;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        // A completion arriving in the final allowed cycle still wins over timeout.
        if (alu_done) begin
          if (w_op == OP_BEQZ) begin
            pc_d    = alu_zero ? w_target : w_pc_inc;
            ret_d   = w_ret_inc;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB: begin
        pc_d    = w_pc_inc;
        ret_d   = w_ret_inc;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes decode from registered state only; instr_in never reaches an output.
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign alu_op    = ir_q[31:26];
  assign alu_start = (state_q == S_EXEC) && (tmo_q == '0);
  assign rf_we     = (state_q == S_WB);
  assign fetch_en  = (state_q == S_FETCH);
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign retired   = ret_q;

endmodule
`default_nettype wire

// File: tb/tb_harvard_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_harvard_seq_ctrl
// Purpose  : Scoreboard bench for harvard_seq_ctrl with instruction memory and
//            a configurable-latency ALU responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_harvard_seq_ctrl;

  localparam int PC_W  = 6;
  localparam int CNT_W = 16;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  logic             clk = 1'b0;
  logic             reset, start, alu_done, alu_zero;
  logic [31:0]      instr_in;
  logic [PC_W-1:0]  pc;
  logic [31:0]      ir;
  logic             alu_start, rf_we, fetch_en, halted, err;
  logic [5:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  logic [31:0]      imem [0:(1<<PC_W)-1];
  logic [PC_W-1:0]  exp_pc_q [$];

  int   n_vec = 0;
  int   n_err = 0;
  int   rf_we_cnt, alu_start_cnt, exec_cnt, exec_i, alu_delay;
  logic zero_val, alu_noise;
  logic [5:0] start_op;

  always #5 clk = ~clk;

  assign instr_in = imem[pc];

  harvard_seq_ctrl #(.PC_W(PC_W), .ALU_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .alu_done(alu_done), .alu_zero(alu_zero), .pc(pc), .ir(ir),
    .alu_start(alu_start), .alu_op(alu_op), .rf_we(rf_we), .fetch_en(fetch_en),
    .state(state), .halted(halted), .err(err), .retired(retired)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [25:0] lo);
    return {op, lo};
  endfunction

  // Called at a negedge: score the current cycle, drive the ALU, advance one clock.
  task automatic step();
    logic [PC_W-1:0] exp;
    if (fetch_en) begin
      n_vec++;
      if (exp_pc_q.size() == 0) begin
        n_err++;
        $display("FAIL fetch_pc: fetch at pc=%0h, required no fetch", pc);
      end else begin
        exp = exp_pc_q.pop_front();
        if (pc !== exp) begin
          n_err++;
          $display("FAIL fetch_pc: got %0h want %0h", pc, exp);
        end
      end
    end
    if (rf_we) rf_we_cnt++;
    if (alu_start) begin
      alu_start_cnt++;
      start_op = alu_op;
      exec_i   = 0;
    end
    if (state == 3'd3) begin
      alu_done = (alu_delay >= 0) && (exec_i == alu_delay);
      alu_zero = zero_val;
      exec_i++;
      exec_cnt++;
    end else begin
      alu_done = alu_noise;
      alu_zero = alu_noise;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    exp_pc_q.delete();
    rf_we_cnt = 0; alu_start_cnt = 0; exec_cnt = 0; exec_i = 0;
    alu_delay = 0; zero_val = 1'b0; alu_noise = 1'b0; start_op = 6'h00;
  endtask

  task automatic load_all_halt();
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = I_HALT;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_sb();
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_halt(input int budget, output int cycles);
    cycles = 0;
    while (!halted && cycles < budget) begin
      step();
      cycles++;
    end
    n_vec++;
    if (!halted) begin
      n_err++;
      $display("FAIL halt_timeout: not halted after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    int cyc;
    load_all_halt();
    clear_sb();
    reset = 1'b1; start = 1'b1; alu_done = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    n_vec++; if (pc !== '0) begin n_err++; $display("FAIL reset_pc: got %0h want 0", pc); end
    n_vec++; if (ir !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %0h want 0", ir); end
    n_vec++;
    if ({alu_start, rf_we, fetch_en, halted, err} !== 5'b0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 00000", {alu_start, rf_we, fetch_en, halted, err});
    end
    n_vec++; if (retired !== '0) begin n_err++; $display("FAIL reset_retired: got %0d want 0", retired); end
    reset = 1'b0;
    exp_pc_q.push_back(6'h00);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL start_fetch: state got %0d want 1", state); end
    n_vec++; if (fetch_en !== 1'b1) begin n_err++; $display("FAIL start_fetch_en: got %b want 1", fetch_en); end
    run_until_halt(20, cyc);
    n_vec++; if (retired !== '0) begin n_err++; $display("FAIL halt_not_counted: retired got %0d want 0", retired); end
  endtask

  task automatic test_alu_program();
    int cyc;
    do_reset();
    load_all_halt();
    imem[0] = enc(6'h01, 26'h0001234);
    imem[1] = I_NOP;
    imem[2] = I_HALT;
    alu_delay = 0;
    exp_pc_q.push_back(6'd0); exp_pc_q.push_back(6'd1); exp_pc_q.push_back(6'd2);
    launch();
    run_until_halt(30, cyc);
    n_vec++; if (cyc != 8) begin n_err++; $display("FAIL alu_prog_latency: got %0d want 8", cyc); end
    n_vec++; if (rf_we_cnt != 1) begin n_err++; $display("FAIL alu_prog_rf_we: got %0d pulses want 1", rf_we_cnt); end
    n_vec++; if (alu_start_cnt != 1) begin n_err++; $display("FAIL alu_prog_start: got %0d pulses want 1", alu_start_cnt); end
    n_vec++; if (start_op !== 6'h01) begin n_err++; $display("FAIL alu_prog_op: got %0h want 01", start_op); end
    n_vec++; if (pc !== 6'd2) begin n_err++; $display("FAIL alu_prog_pc: got %0d want 2", pc); end
    n_vec++; if (retired !== 16'd2) begin n_err++; $display("FAIL alu_prog_retired: got %0d want 2", retired); end
    start = 1'b1;
    repeat (4) step();
    start = 1'b0;
    n_vec++; if (state !== 3'd5 || halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: state got %0d want 5", state); end
    n_vec++; if (pc !== 6'd2) begin n_err++; $display("FAIL halt_pc_hold: got %0d want 2", pc); end
    n_vec++; if (exp_pc_q.size() != 0) begin n_err++; $display("FAIL alu_prog_fetches: %0d pending want 0", exp_pc_q.size()); end
  endtask

  task automatic test_jmp_wrap();
    int cyc;
    do_reset();
    load_all_halt();
    imem[0]    = enc(6'h10, 26'h000003E);
    imem[6'h3E] = I_NOP;
    imem[6'h3F] = I_NOP;
    alu_noise = 1'b1;
    exp_pc_q.push_back(6'h00); exp_pc_q.push_back(6'h3E);
    exp_pc_q.push_back(6'h3F); exp_pc_q.push_back(6'h00);
    launch();
    step();
    imem[0] = I_HALT;
    run_until_halt(30, cyc);
    n_vec++; if (cyc != 7) begin n_err++; $display("FAIL jmp_latency: got %0d want 7", cyc); end
    n_vec++; if (pc !== 6'h00) begin n_err++; $display("FAIL jmp_wrap_pc: got %0h want 00", pc); end
    n_vec++; if (retired !== 16'd3) begin n_err++; $display("FAIL jmp_retired: got %0d want 3", retired); end
    n_vec++; if (alu_start_cnt != 0 || rf_we_cnt != 0) begin n_err++; $display("FAIL jmp_noise: alu_start=%0d rf_we=%0d want 0/0", alu_start_cnt, rf_we_cnt); end
    n_vec++; if (exp_pc_q.size() != 0) begin n_err++; $display("FAIL jmp_fetches: %0d pending want 0", exp_pc_q.size()); end
  endtask

  task automatic test_beqz();
    int cyc;
    for (int z = 1; z >= 0; z--) begin
      do_reset();
      load_all_halt();
      imem[0] = enc(6'h11, 26'h0000020);
      alu_delay = 0;
      zero_val  = (z == 1);
      exp_pc_q.push_back(6'h00);
      exp_pc_q.push_back((z == 1) ? 6'h20 : 6'h01);
      launch();
      run_until_halt(30, cyc);
      n_vec++; if (cyc != 5) begin n_err++; $display("FAIL beqz_latency z=%0d: got %0d want 5", z, cyc); end
      n_vec++;
      if (pc !== ((z == 1) ? 6'h20 : 6'h01)) begin
        n_err++; $display("FAIL beqz_pc z=%0d: got %0h want %0h", z, pc, (z == 1) ? 6'h20 : 6'h01);
      end
      n_vec++; if (rf_we_cnt != 0) begin n_err++; $display("FAIL beqz_rf_we z=%0d: got %0d want 0", z, rf_we_cnt); end
      n_vec++; if (retired !== 16'd1) begin n_err++; $display("FAIL beqz_retired z=%0d: got %0d want 1", z, retired); end
    end
  endtask

  task automatic test_alu_delay();
    int cyc;
    do_reset();
    load_all_halt();
    imem[0] = enc(6'h05, 26'h0);
    alu_delay = 3;
    exp_pc_q.push_back(6'd0); exp_pc_q.push_back(6'd1);
    launch();
    run_until_halt(30, cyc);
    n_vec++; if (cyc != 9) begin n_err++; $display("FAIL delay_latency: got %0d want 9", cyc); end
    n_vec++; if (alu_start_cnt != 1) begin n_err++; $display("FAIL delay_start: got %0d pulses want 1", alu_start_cnt); end
    n_vec++; if (exec_cnt != 4) begin n_err++; $display("FAIL delay_exec_cycles: got %0d want 4", exec_cnt); end
    n_vec++; if (rf_we_cnt != 1) begin n_err++; $display("FAIL delay_rf_we: got %0d want 1", rf_we_cnt); end
    n_vec++; if (retired !== 16'd1) begin n_err++; $display("FAIL delay_retired: got %0d want 1", retired); end
  endtask

  task automatic test_timeout();
    int cyc;
    do_reset();
    load_all_halt();
    imem[0] = enc(6'h02, 26'h0);
    alu_delay = -1;
    exp_pc_q.push_back(6'd0);
    launch();
    run_until_halt(40, cyc);
    n_vec++; if (exec_cnt != 15) begin n_err++; $display("FAIL timeout_exec_cycles: got %0d want 15", exec_cnt); end
    n_vec++; if (err !== 1'b1 || halted !== 1'b1) begin n_err++; $display("FAIL timeout_err: err=%b halted=%b want 1/1", err, halted); end
    n_vec++; if (rf_we_cnt != 0) begin n_err++; $display("FAIL timeout_rf_we: got %0d want 0", rf_we_cnt); end
    n_vec++; if (retired !== '0 || pc !== '0) begin n_err++; $display("FAIL timeout_state: retired=%0d pc=%0d want 0/0", retired, pc); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (err !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL err_clear: err=%b halted=%b want 0/0", err, halted); end
  endtask

  task automatic test_reset_mid_exec();
    int n;
    do_reset();
    load_all_halt();
    imem[0] = I_NOP;
    imem[1] = enc(6'h03, 26'h0);
    alu_delay = -1;
    exp_pc_q.push_back(6'd0); exp_pc_q.push_back(6'd1);
    launch();
    n = 0;
    while (state != 3'd3 && n < 10) begin step(); n++; end
    n_vec++; if (state !== 3'd3 || alu_start !== 1'b1) begin n_err++; $display("FAIL mid_reach_exec: state=%0d alu_start=%b want 3/1", state, alu_start); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", state); end
    n_vec++; if (pc !== '0) begin n_err++; $display("FAIL mid_pc: got %0d want 0", pc); end
    n_vec++; if (err !== 1'b0 || retired !== '0) begin n_err++; $display("FAIL mid_err_ret: err=%b retired=%0d want 0/0", err, retired); end
    repeat (5) step();
    n_vec++; if (alu_start_cnt != 1) begin n_err++; $display("FAIL mid_alu_start: got %0d want 1", alu_start_cnt); end
    n_vec++; if (rf_we_cnt != 0) begin n_err++; $display("FAIL mid_rf_we: got %0d want 0", rf_we_cnt); end
    n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL mid_idle_hold: got %0d want 0", state); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
    test_reset();
    test_alu_program();
    test_jmp_wrap();
    test_beqz();
    test_alu_delay();
    test_timeout();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
